// File: rtl/mem_load_stage.sv
// MEM pipeline stage that waits on variable-latency data RAM responses and buffers load data while WB stalls.
// Optional sub-word load extraction is enabled by defining MEM_SUBWORD_LOAD_EN.
module mem_load_stage #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RF_ADDR_W = 5,
   parameter int unsigned PC_W      = 32
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [RF_ADDR_W+DATA_W+PC_W+6:0]  EXE_to_MEM_bus,
   input  logic                              EXE_to_MEM_valid,
   output logic                              MEM_allow_in,
   input  logic                              data_ram_rsp_valid,
   input  logic [DATA_W-1:0]                 data_ram_r_data,
   output logic [RF_ADDR_W+DATA_W+PC_W+2:0]  MEM_to_WB_bus,
   output logic                              MEM_to_WB_valid,
   input  logic                              WB_allow_in,
   output logic [DATA_W+RF_ADDR_W+2:0]       MEM_to_BY_bus
);

   localparam int unsigned IN_W    = RF_ADDR_W + DATA_W + PC_W + 7;
   localparam int unsigned OFF_W   = $clog2(DATA_W / 8);
   localparam int unsigned ALU_LSB = RF_ADDR_W;
   localparam int unsigned PC_LSB  = ALU_LSB + DATA_W;
   localparam int unsigned LD_BIT  = PC_LSB + PC_W;
   localparam int unsigned LT_LSB  = LD_BIT + 1;
   localparam int unsigned WE_BIT  = LT_LSB + 3;
   localparam int unsigned SEL_LSB = WE_BIT + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } load_state_t;

   load_state_t           state;
   logic                  mem_valid;
   logic [IN_W-1:0]       in_q;
   logic [DATA_W-1:0]     rdata_buf;

   logic [RF_ADDR_W-1:0]  rf_waddr;
   logic [DATA_W-1:0]     alu_res;
   logic [PC_W-1:0]       pc_plus_8;
   logic                  is_load;
   logic [2:0]            load_type;
   logic                  rf_we;
   logic [1:0]            sel_rf_w_data;

   logic                  mem_ready_go;
   logic                  accept;
   logic                  load_enter;
   logic                  load_pending;
   logic [DATA_W-1:0]     raw_data;
   logic [DATA_W-1:0]     load_data;
   logic [DATA_W-1:0]     rf_wdata;

   assign rf_waddr      = in_q[RF_ADDR_W-1:0];
   assign alu_res       = in_q[ALU_LSB +: DATA_W];
   assign pc_plus_8     = in_q[PC_LSB +: PC_W];
   assign is_load       = in_q[LD_BIT];
   assign load_type     = in_q[LT_LSB +: 3];
   assign rf_we         = in_q[WE_BIT];
   assign sel_rf_w_data = in_q[SEL_LSB +: 2];

   // Handshake: a load is ready when its response is on the bus now or already buffered
   assign mem_ready_go    = ~is_load | ((state == ST_WAIT) & data_ram_rsp_valid) | (state == ST_HOLD);
   assign MEM_allow_in    = ~mem_valid | (WB_allow_in & mem_ready_go);
   assign MEM_to_WB_valid = mem_valid & mem_ready_go;
   assign load_pending    = mem_valid & is_load & ~mem_ready_go;
   assign accept          = EXE_to_MEM_valid & MEM_allow_in;
   assign load_enter      = accept & EXE_to_MEM_bus[LD_BIT];

   // Stage register, load tracking FSM and response buffer
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         mem_valid <= 1'b0;
         in_q      <= '0;
         rdata_buf <= '0;
      end else begin
         if (MEM_allow_in) begin
            mem_valid <= EXE_to_MEM_valid;
         end
         if (accept) begin
            in_q <= EXE_to_MEM_bus;
         end
         if ((state == ST_WAIT) && data_ram_rsp_valid && !WB_allow_in) begin
            rdata_buf <= data_ram_r_data;
         end
         case (state)
            ST_IDLE: begin
               if (load_enter) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (data_ram_rsp_valid) begin
                  if (!WB_allow_in)     state <= ST_HOLD;
                  else if (load_enter)  state <= ST_WAIT;
                  else                  state <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (WB_allow_in) state <= load_enter ? ST_WAIT : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign raw_data = (state == ST_HOLD) ? rdata_buf : data_ram_r_data;

`ifdef MEM_SUBWORD_LOAD_EN
   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;
   localparam logic [2:0] LT_LWU = 3'b101;

   logic [OFF_W-1:0] off_b;
   logic [OFF_W-1:0] off_h;
   logic [OFF_W-1:0] off_w;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [31:0]      word_v;

   // Little-endian lane select; half/word lanes ignore the low offset bits
   always_comb begin
      off_b     = alu_res[OFF_W-1:0];
      off_h     = off_b & ~OFF_W'(1);
      off_w     = off_b & ~OFF_W'(3);
      byte_v    = 8'(raw_data >> {off_b, 3'b000});
      half_v    = 16'(raw_data >> {off_h, 3'b000});
      word_v    = 32'(raw_data >> {off_w, 3'b000});
      load_data = raw_data;
      case (load_type)
         LT_LB:   load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
         LT_LBU:  load_data = DATA_W'(byte_v);
         LT_LH:   load_data = {{(DATA_W-16){half_v[15]}}, half_v};
         LT_LHU:  load_data = DATA_W'(half_v);
         LT_LWU:  load_data = DATA_W'(word_v);
         default: load_data = raw_data;
      endcase
   end
`else
   logic unused_load_type;
   assign unused_load_type = ^load_type;
   assign load_data        = raw_data;
`endif

   // Write-back value select
   always_comb begin
      rf_wdata = alu_res;
      case (sel_rf_w_data)
         2'b10:   rf_wdata = load_data;
         2'b01:   rf_wdata = DATA_W'(pc_plus_8);
         2'b11:   rf_wdata = '0;
         default: rf_wdata = alu_res;
      endcase
   end

   assign MEM_to_WB_bus = {sel_rf_w_data, rf_we, pc_plus_8, rf_wdata, rf_waddr};
   assign MEM_to_BY_bus = {load_pending, rf_we, mem_valid, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_load_stage.sv
// Scoreboard bench for mem_load_stage: randomized and directed traffic against a transaction-level model.
module tb_mem_load_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned PW = 32;

   logic                clk = 1'b0;
   logic                resetn;
   logic [AW+DW+PW+6:0] EXE_to_MEM_bus;
   logic                EXE_to_MEM_valid;
   logic                MEM_allow_in;
   logic                data_ram_rsp_valid;
   logic [DW-1:0]       data_ram_r_data;
   logic [AW+DW+PW+2:0] MEM_to_WB_bus;
   logic                MEM_to_WB_valid;
   logic                WB_allow_in;
   logic [DW+AW+2:0]    MEM_to_BY_bus;

   mem_load_stage #(.DATA_W(DW), .RF_ADDR_W(AW), .PC_W(PW)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .EXE_to_MEM_bus     (EXE_to_MEM_bus),
      .EXE_to_MEM_valid   (EXE_to_MEM_valid),
      .MEM_allow_in       (MEM_allow_in),
      .data_ram_rsp_valid (data_ram_rsp_valid),
      .data_ram_r_data    (data_ram_r_data),
      .MEM_to_WB_bus      (MEM_to_WB_bus),
      .MEM_to_WB_valid    (MEM_to_WB_valid),
      .WB_allow_in        (WB_allow_in),
      .MEM_to_BY_bus      (MEM_to_BY_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        is_load;
      bit [2:0]  lt;
      bit [4:0]  waddr;
      bit [31:0] alu;
      bit [31:0] pc;
      bit [31:0] rdata;
      bit [31:0] wdata;
      bit        we;
      bit [1:0]  sel;
      int        d;
   } instr_t;

   int     checks = 0;
   int     errors = 0;
   instr_t sbq[$];
   instr_t pend;
   bit     mon_en = 1'b0;

   // Transaction-level view of the instruction sitting in MEM
   bit        occ = 1'b0;
   bit        occ_load = 1'b0;
   bit        have = 1'b0;
   bit        occ_we = 1'b0;
   bit [4:0]  occ_waddr = '0;
   bit [31:0] occ_data = '0;
   int        c = 0;
   int        d = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit [31:0] ref_load(instr_t i);
      bit [31:0] b;
      bit [31:0] h;
      int        off;
      off = int'(i.alu[1:0]);
      b   = (i.rdata >> (8 * off)) & 32'h0000_00FF;
      h   = (i.rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
`ifdef MEM_SUBWORD_LOAD_EN
      case (i.lt)
         3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'd2:    return b;
         3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4:    return h;
         default: return i.rdata;
      endcase
`else
      if ((b | h) == 32'hFFFF_FFFF) return i.rdata;
      return i.rdata;
`endif
   endfunction

   function automatic bit [31:0] ref_wdata(instr_t i);
      case (i.sel)
         2'b10:   return ref_load(i);
         2'b01:   return i.pc;
         2'b11:   return 32'h0;
         default: return i.alu;
      endcase
   endfunction

   function automatic instr_t gen_rand();
      instr_t i;
      int     r;
      i.is_load = 1'($urandom_range(0, 1));
      i.waddr   = 5'($urandom);
      i.alu     = $urandom;
      i.pc      = $urandom;
      i.we      = 1'($urandom_range(0, 1));
      i.lt      = 3'($urandom_range(0, 5));
      i.rdata   = $urandom;
      i.d       = $urandom_range(0, 3);
      if (i.is_load) begin
         i.sel = 2'b10;
      end else begin
         r     = $urandom_range(0, 2);
         i.sel = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      end
      i.wdata = ref_wdata(i);
      return i;
   endfunction

   function automatic instr_t mk(bit ld, bit [2:0] lt, bit [31:0] alu, bit [31:0] rdata,
                                 int dly, bit [1:0] sel, bit [31:0] exp_w);
      instr_t i;
      i.is_load = ld;
      i.lt      = lt;
      i.waddr   = 5'(alu[6:2]);
      i.alu     = alu;
      i.pc      = 32'h0000_4008;
      i.rdata   = rdata;
      i.wdata   = exp_w;
      i.we      = 1'b1;
      i.sel     = sel;
      i.d       = dly;
      return i;
   endfunction

   // One clock: drive at negedge, check handshake against the model, advance the model at posedge
   task automatic step(input bit v_in, input bit wb_in, input bit rst_in, input bit stray,
                       output bit accepted);
      bit waiting;
      bit rsp_now;
      bit ready;
      bit exp_allow;
      waiting   = occ && occ_load && !have;
      rsp_now   = waiting && (c == d);
      ready     = !occ_load || have || rsp_now;
      exp_allow = !occ || (wb_in && ready);
      resetn             = !rst_in;
      EXE_to_MEM_valid   = v_in;
      EXE_to_MEM_bus     = {pend.sel, pend.we, pend.lt, pend.is_load, pend.pc, pend.alu, pend.waddr};
      WB_allow_in        = wb_in;
      data_ram_rsp_valid = rsp_now || (stray && !waiting);
      data_ram_r_data    = rsp_now ? occ_data : $urandom;
      #1;
      chk("allow_in", 80'(MEM_allow_in), 80'(exp_allow));
      chk("wb_valid", 80'(MEM_to_WB_valid), 80'(occ && ready));
      chk("load_pending", 80'(MEM_to_BY_bus[39]), 80'(occ && occ_load && !ready));
      chk("by_valid", 80'(MEM_to_BY_bus[37]), 80'(occ));
      if (occ) begin
         chk("by_we", 80'(MEM_to_BY_bus[38]), 80'(occ_we));
         chk("by_waddr", 80'(MEM_to_BY_bus[36:32]), 80'(occ_waddr));
      end
      accepted = !rst_in && v_in && exp_allow;
      if (accepted) sbq.push_back(pend);
      @(posedge clk);
      if (rst_in) begin
         occ  = 1'b0;
         have = 1'b0;
         sbq.delete();
      end else if (exp_allow) begin
         occ       = v_in;
         occ_load  = pend.is_load;
         occ_we    = pend.we;
         occ_waddr = pend.waddr;
         occ_data  = pend.rdata;
         have      = 1'b0;
         c         = 0;
         d         = pend.d;
      end else if (rsp_now) begin
         have = 1'b1;
      end else if (waiting) begin
         c++;
      end
      @(negedge clk);
   endtask

   // Monitor: compare whatever MEM presents against the head of the scoreboard
   initial begin
      instr_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && resetn === 1'b1 && MEM_to_WB_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%h required=none", MEM_to_WB_bus);
            end else begin
               e = sbq[0];
               chk("wb_bus", 80'(MEM_to_WB_bus), 80'({e.sel, e.we, e.pc, e.wdata, e.waddr}));
               chk("by_wdata", 80'(MEM_to_BY_bus[31:0]), 80'(e.wdata));
               if (WB_allow_in) void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      bit acc;
      bit pend_active;
      bit v;
      resetn             = 1'b0;
      EXE_to_MEM_valid   = 1'b0;
      EXE_to_MEM_bus     = '0;
      WB_allow_in        = 1'b1;
      data_ram_rsp_valid = 1'b0;
      data_ram_r_data    = '0;
      pend               = mk(1'b0, 3'd0, 32'h0, 32'h0, 0, 2'b00, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_allow_in", 80'(MEM_allow_in), 80'(1'b1));
      chk("rst_wb_valid", 80'(MEM_to_WB_valid), 80'(1'b0));
      chk("rst_wb_bus", 80'(MEM_to_WB_bus), 80'(0));
      chk("rst_by_bus", 80'(MEM_to_BY_bus), 80'(0));
      mon_en = 1'b1;

      // ALU result passes straight through
      pend = mk(1'b0, 3'd0, 32'h1234_5678, 32'h0, 0, 2'b00, 32'h1234_5678);
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, 1'b0, 1'b0, acc);

      // LB / LBU at byte offset 2, response in first MEM cycle
`ifdef MEM_SUBWORD_LOAD_EN
      pend = mk(1'b1, 3'd1, 32'h1000_0002, 32'h0080_0000, 0, 2'b10, 32'hFFFF_FF80);
`else
      pend = mk(1'b1, 3'd1, 32'h1000_0002, 32'h0080_0000, 0, 2'b10, 32'h0080_0000);
`endif
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, 1'b0, 1'b0, acc);
`ifdef MEM_SUBWORD_LOAD_EN
      pend = mk(1'b1, 3'd2, 32'h1000_0002, 32'h0080_0000, 0, 2'b10, 32'h0000_0080);
`else
      pend = mk(1'b1, 3'd2, 32'h1000_0002, 32'h0080_0000, 0, 2'b10, 32'h0080_0000);
`endif
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, 1'b0, 1'b0, acc);

      // LH at offset 2 with a 3-cycle response delay
`ifdef MEM_SUBWORD_LOAD_EN
      pend = mk(1'b1, 3'd3, 32'h2000_0002, 32'hBEEF_0000, 3, 2'b10, 32'hFFFF_BEEF);
`else
      pend = mk(1'b1, 3'd3, 32'h2000_0002, 32'hBEEF_0000, 3, 2'b10, 32'hBEEF_0000);
`endif
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, acc);

      // Response while WB stalls: held, stable, next instruction blocked until release
      pend = mk(1'b1, 3'd0, 32'h3000_0000, 32'hCAFE_F00D, 1, 2'b10, 32'hCAFE_F00D);
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      pend = mk(1'b0, 3'd0, 32'h0000_1111, 32'h0, 0, 2'b01, 32'h0000_4008);
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      step(1'b1, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, 1'b0, 1'b0, acc);

      // Reset while waiting drops the load; a late response is ignored
      pend = mk(1'b1, 3'd0, 32'h4000_0000, 32'h5555_AAAA, 3, 2'b10, 32'h5555_AAAA);
      step(1'b1, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 1'b1, 1'b1, 1'b0, acc);
      step(1'b0, 1'b1, 1'b0, 1'b1, acc);
      step(1'b0, 1'b1, 1'b0, 1'b0, acc);

      // Randomized traffic with stalls, stray responses and occasional resets
      pend_active = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, acc);
            pend_active = 1'b0;
         end else begin
            v = pend_active ? 1'b1 : ($urandom_range(0, 4) != 0);
            if (v && !pend_active) begin
               pend        = gen_rand();
               pend_active = 1'b1;
            end
            step(v, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 3) == 0, acc);
            if (acc) pend_active = 1'b0;
         end
      end
      repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0, acc);
      chk("drain", 80'(sbq.size()), 80'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_load_stage.md
# mem_load_stage

Parametrised memory stage of the five-stage pipeline, between EXE and WB. Unlike the fixed single-cycle MEM stage, it tolerates variable-latency data RAM responses by waiting on a response-valid strobe. It holds captured load data while WB is stalled and extracts sign- or zero-extended sub-word loads. It selects the register write-back value and drives the bypass bus, including a pending flag so ID can stall on load-use hazards.

## Interface
Parameters:
- DATA_W, 32: datapath width; legal values 32 or 64.
- RF_ADDR_W, 5: register-file address width.
- PC_W, 32: PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- EXE_to_MEM_bus  in  RF_ADDR_W+DATA_W+PC_W+7  fields, LSB first:
  - rf_waddr
  - alu_res
  - pc_plus_8
  - is_load
  - load_type[2:0]: 000 LW (LD when DATA_W=64), 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWU (64-bit only)
  - rf_we
  - sel_rf_w_data[1:0]
- EXE_to_MEM_valid  in  1  EXE holds a valid instruction.
- MEM_allow_in  out  1  MEM accepts EXE_to_MEM_bus this cycle.
- data_ram_rsp_valid  in  1  data_ram_r_data is valid this cycle.
- data_ram_r_data  in  DATA_W  aligned RAM read word.
- MEM_to_WB_bus  out  RF_ADDR_W+DATA_W+PC_W+3  fields, LSB first: rf_waddr, rf_wdata, pc_plus_8, rf_we, sel_rf_w_data.
- MEM_to_WB_valid  out  1  MEM presents a completed instruction.
- WB_allow_in  in  1  WB accepts this cycle.
- MEM_to_BY_bus  out  DATA_W+RF_ADDR_W+3  fields, LSB first: rf_wdata, rf_waddr, MEM_valid, rf_we, load_pending.

## Operation
- Input register: loads the bus when EXE_to_MEM_valid & MEM_allow_in. MEM_valid loads EXE_to_MEM_valid whenever MEM_allow_in is high.
- Pipeline control:
  - MEM_allow_in = ~MEM_valid | (WB_allow_in & MEM_ready_go).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- Load FSM states:
  - IDLE: no load outstanding.
  - WAIT: valid load, response not yet seen.
  - HOLD: response captured in rdata_buf while WB is stalled.
- Load FSM transitions:
  - IDLE→WAIT when a load enters MEM.
  - WAIT→IDLE on data_ram_rsp_valid & WB_allow_in.
  - WAIT→HOLD on data_ram_rsp_valid & ~WB_allow_in.
  - HOLD→IDLE on WB_allow_in.
  - A new load entering in the same cycle as any exit to IDLE goes directly to WAIT.
- MEM_ready_go = ~is_load | (state==WAIT & data_ram_rsp_valid) | state==HOLD.
- Raw load data is data_ram_r_data in WAIT and rdata_buf in HOLD.
- Extraction:
  - Byte offset is alu_res[log2(DATA_W/8)-1:0], little-endian.
  - Half-word offset ignores bit 0.
  - LB/LH sign-extend to DATA_W; LBU/LHU/LWU zero-extend.
- rf_wdata selection by sel_rf_w_data:
  - 10: extracted load data
  - 01: pc_plus_8, zero-extended to DATA_W
  - 11: 0
  - 00: alu_res
- load_pending = MEM_valid & is_load & ~MEM_ready_go. While it is high, rf_wdata on the bypass bus is don't-care.
- data_ram_rsp_valid outside WAIT is discarded.

## Timing
- Reset (resetn=0 at a clock edge), effective next cycle:
  - MEM_valid=0, state=IDLE, rdata_buf=0, input register=0.
  - MEM_to_WB_valid=0, MEM_allow_in=1, load_pending=0, all bus outputs 0.
- Non-load latency: one cycle through MEM; the result appears on MEM_to_WB_bus in the cycle after acceptance.
- Load latency: 0 extra cycles if the response arrives in the first MEM cycle, otherwise N extra cycles for an N-cycle response delay.
- The response is captured on the edge where WAIT & data_ram_rsp_valid & ~WB_allow_in.
- Reset asserted while in WAIT or HOLD drops the instruction; a response arriving after reset is ignored.
- A back-to-back load may enter while the previous load completes; its response must arrive in a later cycle.

## Configuration
- MEM_SUBWORD_LOAD_EN defined: full load_type decoding as above.
- MEM_SUBWORD_LOAD_EN undefined:
  - Extraction logic is removed; every load returns the raw DATA_W word.
  - load_type is ignored.
  - Handshake and FSM behaviour are unchanged.

## Test plan
- ALU op, alu_res=0x1234_5678, sel=00, WB_allow_in=1 -> next cycle MEM_to_WB_valid=1, rf_wdata=0x1234_5678.
- LB at alu_res[1:0]=2, r_data=0x0080_0000, response in the first MEM cycle -> rf_wdata=0xFFFF_FF80. Same case with LBU -> 0x0000_0080.
- LH at offset 2 with 3-cycle response delay, r_data=0xBEEF_0000 -> load_pending=1 and MEM_allow_in=0 for 3 cycles, then rf_wdata=0xFFFF_BEEF.
- Response with WB_allow_in=0 for 2 cycles -> state HOLD, MEM_to_WB_valid stays 1 with stable data; proceeds when WB_allow_in rises.
- Load in WAIT, resetn pulsed low, then data_ram_rsp_valid=1 -> MEM_to_WB_valid remains 0, state=IDLE.
- Without MEM_SUBWORD_LOAD_EN: LB with r_data=0x0080_0000 -> rf_wdata=0x0080_0000.
